// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the core/loader memory arbiter.
// Owner encoding, default bus widths and the memory read latency live here.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE       = 2'd0,
        OWN_CORE       = 2'd1,
        OWN_LDR        = 2'd2,
        OWN_LDR_LOCKED = 2'd3
    } owner_e;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int MEM_LAT    = 1;

    // Bits needed to hold a saturating count of 0..max inclusive.
    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the core port, loader port, memory port and arbiter status.
// The arbiter uses the slave view; the environment (requesters + memory) uses master.
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
) ();
    import mem_arb_pkg::*;

    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    logic              l_req;
    logic              l_we;
    logic              l_lock;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              locked;
    owner_e            owner;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  l_req, l_we, l_lock, l_addr, l_wdata,
        output l_gnt, l_rvalid, l_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output locked, owner
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output l_req, l_we, l_lock, l_addr, l_wdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  locked, owner
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX; clear beats increment, reset is sync active-low.
module sat_counter #(
    parameter int W   = 3,
    parameter int MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MAX_V)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_arbiter.sv
// Core-priority arbiter for the shared instruction/data memory, with a starvation
// bound for the loader and a bounded loader lock for burst program loads.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4,
    parameter int LOCK_MAX   = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int SW = cnt_w(STARVE_MAX);
    localparam int LW = cnt_w(LOCK_MAX);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [LW-1:0] LOCK_LIM   = LW'(LOCK_MAX);

    logic [SW-1:0]     w_starve_cnt;
    logic [LW-1:0]     w_lock_cnt;
    logic              w_c_gnt;
    logic              w_l_gnt;
    logic              w_lock_drop;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    logic              r_lock_active;
    logic              r_pend_c;
    logic              r_pend_l;
    owner_e            r_owner;

    // Grant is combinational from the requests and registered counters; nothing granted in reset.
    always_comb begin
        w_c_gnt = 1'b0;
        w_l_gnt = 1'b0;
        if (rst) begin
            if (r_lock_active && (w_lock_cnt < LOCK_LIM) && bus.l_req) begin
                w_l_gnt = 1'b1;
            end else if (bus.l_req && (w_starve_cnt == STARVE_LIM)) begin
                w_l_gnt = 1'b1;
            end else if (bus.c_req) begin
                w_c_gnt = 1'b1;
            end else if (bus.l_req) begin
                w_l_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_c_gnt) begin
            w_mem_we    = bus.c_we;
            w_mem_addr  = bus.c_addr;
            w_mem_wdata = bus.c_wdata;
        end else if (w_l_gnt) begin
            w_mem_we    = bus.l_we;
            w_mem_addr  = bus.l_addr;
            w_mem_wdata = bus.l_wdata;
        end
    end

    // A core grant while locked can only be the forced slot at LOCK_MAX, so it ends the lock.
    assign w_lock_drop = (w_l_gnt && !bus.l_lock) || !bus.l_req || w_c_gnt;

    sat_counter #(.W(SW), .MAX(STARVE_MAX)) u_starve_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_c_gnt && bus.l_req),
        .i_clr (w_l_gnt || !bus.l_req),
        .o_cnt (w_starve_cnt)
    );

    sat_counter #(.W(LW), .MAX(LOCK_MAX)) u_lock_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_l_gnt && bus.l_lock),
        .i_clr (w_lock_drop),
        .o_cnt (w_lock_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lock_active <= 1'b0;
            r_pend_c      <= 1'b0;
            r_pend_l      <= 1'b0;
            r_owner       <= OWN_NONE;
        end else begin
            r_pend_c <= w_c_gnt && !bus.c_we;
            r_pend_l <= w_l_gnt && !bus.l_we;
            if (w_l_gnt && bus.l_lock) begin
                r_lock_active <= 1'b1;
            end else if (w_lock_drop) begin
                r_lock_active <= 1'b0;
            end
            if (w_c_gnt) begin
                r_owner <= OWN_CORE;
            end else if (w_l_gnt) begin
                r_owner <= bus.l_lock ? OWN_LDR_LOCKED : OWN_LDR;
            end
        end
    end

    assign bus.c_gnt     = w_c_gnt;
    assign bus.l_gnt     = w_l_gnt;
    assign bus.mem_en    = w_c_gnt | w_l_gnt;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    // Status and read-valid are forced low for the whole reset cycle, not just after the edge.
    assign bus.c_rvalid  = r_pend_c && rst;
    assign bus.l_rvalid  = r_pend_l && rst;
    assign bus.c_rdata   = bus.mem_rdata;
    assign bus.l_rdata   = bus.mem_rdata;
    assign bus.locked    = r_lock_active && rst;
    assign bus.owner     = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and scripted bench for mem_arbiter against a queue-driven reference model
// of the arbitration rules, with a behavioural single-cycle memory behind the arbiter.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int SM = 4;
    localparam int LM = 16;

    typedef struct {
        int          gap;
        bit          we;
        bit          lock;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM), .LOCK_MAX(LM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] tbmem  [64];
    logic [31:0] refmem [64];

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) tbmem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= tbmem[bus.mem_addr[7:2]];
        else bus.mem_rdata <= $urandom;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    req_t cq[$];
    req_t lq[$];
    req_t c_cur, l_cur;
    bit   c_act = 0, l_act = 0;
    int   c_gap = 0, l_gap = 0;

    int     m_starve = 0, m_lcnt = 0;
    bit     m_lock = 0, m_pend_c = 0, m_pend_l = 0;
    logic [31:0] m_rd_c = '0, m_rd_l = '0;
    owner_e m_owner = OWN_NONE;

    int lrun = 0, max_lrun = 0, ph_cyc = 0, first_l_at = -1;
    logic [31:0] last_c_rdata = '0;

    function automatic req_t mk(input int gap, input bit we, input bit lock,
                                input int idx, input logic [31:0] wd);
        req_t r;
        r.gap = gap; r.we = we; r.lock = lock;
        r.addr = 32'(idx) << 2; r.wdata = wd;
        return r;
    endfunction

    task automatic step(input bit rst_lo);
        bit eg_c, eg_l, creq, lreq, exp_we;
        logic [31:0] exp_a, exp_wd;
        if (!c_act && cq.size() > 0) begin c_cur = cq.pop_front(); c_act = 1; c_gap = c_cur.gap; end
        if (!l_act && lq.size() > 0) begin l_cur = lq.pop_front(); l_act = 1; l_gap = l_cur.gap; end
        creq = c_act && (c_gap == 0);
        lreq = l_act && (l_gap == 0);
        rst         = !rst_lo;
        bus.c_req   = creq;  bus.c_we = c_cur.we; bus.c_addr = c_cur.addr; bus.c_wdata = c_cur.wdata;
        bus.l_req   = lreq;  bus.l_we = l_cur.we; bus.l_addr = l_cur.addr; bus.l_wdata = l_cur.wdata;
        bus.l_lock  = l_cur.lock;
        @(negedge clk);

        eg_c = 0; eg_l = 0;
        if (!rst_lo) begin
            if (m_lock && m_lcnt < LM && lreq) eg_l = 1;
            else if (lreq && m_starve == SM)   eg_l = 1;
            else if (creq)                     eg_c = 1;
            else if (lreq)                     eg_l = 1;
        end
        exp_we = 0; exp_a = '0; exp_wd = '0;
        if (eg_c) begin exp_we = c_cur.we; exp_a = c_cur.addr; exp_wd = c_cur.wdata; end
        if (eg_l) begin exp_we = l_cur.we; exp_a = l_cur.addr; exp_wd = l_cur.wdata; end

        chk("c_gnt", bus.c_gnt, eg_c);
        chk("l_gnt", bus.l_gnt, eg_l);
        chk("mem_en", bus.mem_en, eg_c | eg_l);
        chk("mem_we", bus.mem_we, exp_we);
        chk("mem_addr", bus.mem_addr, exp_a);
        chk("mem_wdata", bus.mem_wdata, exp_wd);
        chk("c_rvalid", bus.c_rvalid, m_pend_c && !rst_lo);
        chk("l_rvalid", bus.l_rvalid, m_pend_l && !rst_lo);
        chk("locked", bus.locked, m_lock && !rst_lo);
        if (m_pend_c && !rst_lo) begin
            chk("c_rdata", bus.c_rdata, m_rd_c);
            last_c_rdata = bus.c_rdata;
        end
        if (m_pend_l && !rst_lo) chk("l_rdata", bus.l_rdata, m_rd_l);
        if (!rst_lo) chk("owner", bus.owner, m_owner);

        if (rst_lo) begin
            m_starve = 0; m_lock = 0; m_lcnt = 0;
            m_pend_c = 0; m_pend_l = 0; m_owner = OWN_NONE;
        end else begin
            if (eg_l || !lreq) m_starve = 0;
            else if (eg_c && m_starve < SM) m_starve++;
            if (eg_l && l_cur.lock) begin
                m_lock = 1;
                if (m_lcnt < LM) m_lcnt++;
            end else if ((eg_l && !l_cur.lock) || !lreq || eg_c) begin
                m_lock = 0; m_lcnt = 0;
            end
            m_pend_c = eg_c && !c_cur.we;
            m_pend_l = eg_l && !l_cur.we;
            if (eg_c) begin
                if (c_cur.we) refmem[c_cur.addr[7:2]] = c_cur.wdata;
                else m_rd_c = refmem[c_cur.addr[7:2]];
                m_owner = OWN_CORE;
            end
            if (eg_l) begin
                if (l_cur.we) refmem[l_cur.addr[7:2]] = l_cur.wdata;
                else m_rd_l = refmem[l_cur.addr[7:2]];
                m_owner = l_cur.lock ? OWN_LDR_LOCKED : OWN_LDR;
            end
        end

        if (eg_l) begin
            lrun++;
            if (lrun > max_lrun) max_lrun = lrun;
            if (first_l_at < 0) first_l_at = ph_cyc;
        end else lrun = 0;
        ph_cyc++;

        if (eg_c) c_act = 0; else if (c_act && c_gap > 0) c_gap--;
        if (eg_l) l_act = 0; else if (l_act && l_gap > 0) l_gap--;
        @(posedge clk); #1;
    endtask

    task automatic start_phase();
        lrun = 0; max_lrun = 0; ph_cyc = 0; first_l_at = -1;
    endtask

    task automatic run_phase(input string name, input int budget);
        int n;
        n = 0;
        while ((c_act || l_act || cq.size() > 0 || lq.size() > 0) && n < budget) begin
            step(0);
            n++;
        end
        chk(name, (c_act || l_act || cq.size() > 0 || lq.size() > 0), 0);
        step(0);
        step(0);
    endtask

    initial begin
        if (MEM_LAT != 1) begin
            $display("FAIL mem_lat: got %0d expected 1", MEM_LAT);
            $fatal(1);
        end
        for (int i = 0; i < 64; i++) begin
            tbmem[i]  = 32'hA5000000 ^ (32'(i) * 32'h01010101);
            refmem[i] = 32'hA5000000 ^ (32'(i) * 32'h01010101);
        end
        c_cur = mk(0, 0, 0, 0, '0);
        l_cur = mk(0, 0, 0, 0, '0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) step(1);

        // Core-only read / write / read-back at 0x10.
        start_phase();
        cq.push_back(mk(0, 0, 0, 4, '0));
        cq.push_back(mk(0, 1, 0, 4, 32'hDEADBEEF));
        cq.push_back(mk(0, 0, 0, 4, '0));
        run_phase("core_only_done", 50);
        chk("core_rdback", last_c_rdata, 32'hDEADBEEF);

        // Continuous contention without lock: C x STARVE_MAX then L.
        start_phase();
        for (int i = 0; i < 15; i++) begin
            cq.push_back(mk(0, 0, 0, i, '0));
            lq.push_back(mk(0, 0, 0, 20 + i, '0));
        end
        run_phase("contend_done", 200);
        chk("first_l_at", 64'(first_l_at), SM);

        // Locked loader burst of 20 writes against a busy core.
        start_phase();
        for (int i = 0; i < 20; i++) begin
            cq.push_back(mk(0, 0, 0, i, '0));
            lq.push_back(mk(0, 1, 1, 32 + i, $urandom));
        end
        run_phase("lock_burst_done", 300);
        chk("lock_run", 64'(max_lrun), LM);

        // Locked loader alone: lock counter saturates and the loader keeps going.
        start_phase();
        for (int i = 0; i < 20; i++) lq.push_back(mk(0, 1, 1, 40 + i, $urandom));
        lq.push_back(mk(0, 0, 1, 45, '0));
        lq.push_back(mk(0, 0, 0, 50, '0));
        run_phase("lock_solo_done", 100);
        chk("lock_solo_run", 64'(max_lrun), 22);

        // Alternating core / loader reads.
        start_phase();
        for (int i = 0; i < 10; i++) begin
            cq.push_back(mk(1, 0, 0, i, '0));
            lq.push_back(mk(0, 0, 0, 40 + i, '0));
        end
        run_phase("alt_done", 100);

        // Random traffic.
        start_phase();
        for (int i = 0; i < 150; i++) begin
            cq.push_back(mk($urandom_range(0, 3), 1'($urandom % 2), 0, $urandom_range(0, 63), $urandom));
            lq.push_back(mk($urandom_range(0, 3), 1'($urandom % 2), 1'($urandom % 3 == 0),
                            $urandom_range(0, 63), $urandom));
        end
        run_phase("random_done", 3000);

        // Reset the cycle after a locked loader read grant.
        start_phase();
        for (int i = 0; i < 12; i++) begin
            cq.push_back(mk(0, 0, 0, i, '0));
            lq.push_back(mk(0, 0, 1, 30 + i, '0));
        end
        for (int i = 0; i < SM + 1; i++) step(0);
        chk("pre_rst_l_gnt", 64'(first_l_at), SM);
        step(1);
        start_phase();
        step(0);
        chk("post_rst_core_first", 64'(first_l_at), 64'hFFFF_FFFF_FFFF_FFFF);
        run_phase("post_rst_done", 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
